// File: rtl/vga_text_pkg.sv
// Shared constants and FSM encoding for the monochrome VGA text fetch path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_text_pkg;

    localparam int          FONT_H          = 16;       // glyph lines per character
    localparam int          DEF_COLS        = 80;       // character cells per line
    localparam int          DEF_ROWS        = 30;       // character rows per frame
    localparam logic [12:0] DEF_SCREEN_BASE = 13'h1000; // word address of cell (0,0)
    localparam logic [12:0] DEF_FONT_BASE   = 13'h0000; // word address of glyph 0, line 0

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCR_REQ  = 3'd1,
        SCR_WAIT = 3'd2,
        FNT_REQ  = 3'd3,
        FNT_WAIT = 3'd4,
        FULL     = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/text_fetch_glyph_shifter.sv
// Glyph prefetch buffer plus 8-bit serialiser producing one pixel per i_pix_en.
// Latency: o_pixel is registered, valid the cycle after i_pix_en.
// Backpressure: none; an empty buffer at a cell boundary emits 0 and flags underrun.
//
// Ports: i_clk/i_reset (async, active-high); i_clear drops buffer, shifter and
// cell count at line start; i_wr/i_wr_dat fill the buffer; i_pix_en advances a
// pixel; o_full shows buffer occupancy; o_load pulses when the shifter takes the
// buffer; o_pixel is the serial pixel; o_underrun is sticky until reset.
module glyph_shifter
    import vga_text_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_wr,
    input  logic [7:0] i_wr_dat,
    input  logic       i_pix_en,
    output logic       o_full,
    output logic       o_load,
    output logic       o_pixel,
    output logic       o_underrun
);

    localparam int CELL_W = $clog2(COLS + 1);

    logic [7:0]        buf_q, buf_d;
    logic              full_q, full_d;
    logic [7:0]        sh_q, sh_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CELL_W-1:0] cells_q, cells_d;
    logic              pixel_q, pixel_d;
    logic              underrun_q, underrun_d;
    logic              load;

    always_comb begin
        buf_d      = buf_q;
        full_d     = full_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        cells_d    = cells_q;
        pixel_d    = pixel_q;
        underrun_d = underrun_q;
        load       = 1'b0;

        if (i_clear) begin
            buf_d   = 8'h00;
            full_d  = 1'b0;
            sh_d    = 8'h00;
            cnt_d   = 3'd0;
            cells_d = '0;
        end else begin
            // The buffer is only written while empty, so this never races a load.
            if (i_wr) begin
                buf_d  = i_wr_dat;
                full_d = 1'b1;
            end
            if (i_pix_en) begin
                if (cnt_q != 3'd0) begin
                    pixel_d = sh_q[7];
                    sh_d    = {sh_q[6:0], 1'b0};
                    cnt_d   = cnt_q - 3'd1;
                end else if (full_q) begin
                    load    = 1'b1;
                    pixel_d = buf_q[7];
                    sh_d    = {buf_q[6:0], 1'b0};
                    cnt_d   = 3'd7;
                    full_d  = 1'b0;
                    cells_d = cells_q + CELL_W'(1);
                end else begin
                    // Past the last cell of the line, blank pixels are expected.
                    pixel_d = 1'b0;
                    if (32'(cells_q) != COLS) begin
                        underrun_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_q      <= 8'h00;
            full_q     <= 1'b0;
            sh_q       <= 8'h00;
            cnt_q      <= 3'd0;
            cells_q    <= '0;
            pixel_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            full_q     <= full_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            cells_q    <= cells_d;
            pixel_q    <= pixel_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_full     = full_q;
    assign o_load     = load;
    assign o_pixel    = pixel_q;
    assign o_underrun = underrun_q;

endmodule

// File: rtl/text_fetch.sv
// VGA text line fetcher: reads screen word then font word per cell, serialises glyph rows.
// Latency: first glyph buffered 4 cycles after i_line_start; o_pixel 1 cycle after i_pix_en.
// Backpressure: none; one request outstanding, ack assumed exactly one cycle after o_cs.
//
// Ports: i_clk, i_reset (async, active-high); i_line_start/i_y from the VGA timing
// stage; i_pix_en pixel strobe; o_pixel, o_underrun (sticky); memory initiator
// o_addr/o_cs/o_we with i_dat/i_ack.
// Optional macro TEXT_CURSOR_EN adds i_cursor_on/i_cursor_col/i_cursor_row and
// forces glyph lines 14-15 of the cursor cell to solid.
module text_fetch
    import vga_text_pkg::*;
#(
    parameter int          COLS        = DEF_COLS,
    parameter logic [12:0] SCREEN_BASE = DEF_SCREEN_BASE,
    parameter logic [12:0] FONT_BASE   = DEF_FONT_BASE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_line_start,
    input  logic [8:0]  i_y,
    input  logic        i_pix_en,
`ifdef TEXT_CURSOR_EN
    input  logic        i_cursor_on,
    input  logic [6:0]  i_cursor_col,
    input  logic [4:0]  i_cursor_row,
`endif
    output logic        o_pixel,
    output logic        o_underrun,
    output logic [12:0] o_addr,
    output logic        o_cs,
    output logic        o_we,
    input  logic [15:0] i_dat,
    input  logic        i_ack
);

    localparam int COL_W = $clog2(COLS + 1);

    fetch_state_e      state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [3:0]        gl_q, gl_d;
    logic [7:0]        chr_q, chr_d;

    logic              buf_wr;
    logic [7:0]        buf_wr_dat;
    logic              sh_load;
    logic              sh_full;

    // Upper byte of both screen and font words carries nothing for this path.
    logic              unused_dat_hi;
    assign unused_dat_hi = ^i_dat[15:8];

    always_comb begin
        buf_wr_dat = i_dat[7:0];
`ifdef TEXT_CURSOR_EN
        if (i_cursor_on && (32'(col_q) == 32'(i_cursor_col)) &&
            (row_q == i_cursor_row) && (gl_q >= 4'd14)) begin
            buf_wr_dat = 8'hFF;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        gl_d    = gl_q;
        chr_d   = chr_q;
        buf_wr  = 1'b0;

        // Line start aborts whatever is in flight; an ack for the aborted
        // request then lands in SCR_REQ and is dropped.
        if (i_line_start) begin
            row_d   = i_y[8:4];
            gl_d    = i_y[3:0];
            col_d   = '0;
            state_d = SCR_REQ;
        end else begin
            unique case (state_q)
                IDLE:     state_d = IDLE;
                SCR_REQ:  state_d = SCR_WAIT;
                SCR_WAIT: begin
                    if (i_ack) begin
                        chr_d   = i_dat[7:0];
                        state_d = FNT_REQ;
                    end
                end
                FNT_REQ:  state_d = FNT_WAIT;
                FNT_WAIT: begin
                    if (i_ack) begin
                        buf_wr  = 1'b1;
                        col_d   = col_q + COL_W'(1);
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (sh_load) begin
                        state_d = (32'(col_q) == COLS) ? IDLE : SCR_REQ;
                    end
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_cs   = 1'b0;
        o_addr = 13'h0000;
        if (state_q == SCR_REQ) begin
            o_cs   = 1'b1;
            o_addr = SCREEN_BASE + 13'(32'(row_q) * COLS) + 13'(32'(col_q));
        end else if (state_q == FNT_REQ) begin
            o_cs   = 1'b1;
            o_addr = FONT_BASE + {1'b0, chr_q, gl_q};
        end
    end

    assign o_we = 1'b0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= 5'd0;
            gl_q    <= 4'd0;
            chr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            gl_q    <= gl_d;
            chr_q   <= chr_d;
        end
    end

    glyph_shifter #(
        .COLS (COLS)
    ) u_shifter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_line_start),
        .i_wr       (buf_wr),
        .i_wr_dat   (buf_wr_dat),
        .i_pix_en   (i_pix_en),
        .o_full     (sh_full),
        .o_load     (sh_load),
        .o_pixel    (o_pixel),
        .o_underrun (o_underrun)
    );

    // Occupancy is implied by the FULL state; kept visible for debug.
    logic unused_full;
    assign unused_full = sh_full;

endmodule

// File: tb/tb_text_fetch.sv
module tb_text_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [8:0]  y = 9'd0;
    logic        pix_en = 1'b0;
`ifdef TEXT_CURSOR_EN
    logic        cursor_on = 1'b0;
    logic [6:0]  cursor_col = 7'd0;
    logic [4:0]  cursor_row = 5'd0;
`endif
    logic        pixel;
    logic        underrun;
    logic [12:0] addr;
    logic        cs;
    logic        we;
    logic [15:0] dat = 16'h0000;
    logic        ack = 1'b0;

    int tests = 0;
    int fails = 0;
    int nreq  = 0;

    always #5 clk = ~clk;

    text_fetch dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_line_start (line_start),
        .i_y          (y),
        .i_pix_en     (pix_en),
`ifdef TEXT_CURSOR_EN
        .i_cursor_on  (cursor_on),
        .i_cursor_col (cursor_col),
        .i_cursor_row (cursor_row),
`endif
        .o_pixel      (pixel),
        .o_underrun   (underrun),
        .o_addr       (addr),
        .o_cs         (cs),
        .o_we         (we),
        .i_dat        (dat),
        .i_ack        (ack)
    );

    // Screen cell (r,c) holds code 0x41 + c + 8r with junk in the high byte.
    // Font line = code ^ {gl,gl}, except glyph 0x41 line 3 which is 0xA5.
    function automatic logic [15:0] mem_rd(input logic [12:0] a);
        int         off;
        logic [7:0] code;
        if (a >= 13'h1000) begin
            off  = int'(a) - 32'h1000;
            code = 8'(32'h41 + (off % 80) + (off / 80) * 8);
            return {8'hC3, code};
        end
        if (a == 13'h0413) return 16'h5AA5;
        return {8'h5A, a[11:4] ^ {a[3:0], a[3:0]}};
    endfunction

    // Responder: ack and data exactly one cycle after each strobe.
    always @(posedge clk) begin
        ack <= cs;
        dat <= mem_rd(addr);
        if (cs) nreq <= nreq + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grab_byte(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            b = {b[6:0], pixel};
        end
    endtask

    task automatic start_line(input logic [8:0] yy);
        line_start = 1'b1;
        y = yy;
        step();
        line_start = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [7:0]  code;
        logic [15:0] w;
        int          base;

        // Reset state
        #2;
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        #10;
        rst = 1'b0;
        step();

        // Single cell, row 0 line 3: screen then font address, glyph 0xA5
        start_line(9'd3);
        chk("t1_scr_cs", 32'(cs), 32'd1);
        chk("t1_scr_addr", 32'(addr), 32'h1000);
        step();
        chk("t1_wait_cs", 32'(cs), 32'd0);
        step();
        chk("t1_fnt_cs", 32'(cs), 32'd1);
        chk("t1_fnt_addr", 32'(addr), 32'h0413);
        step(); step(); step();
        pix_en = 1'b1;
        grab_byte(b);
        pix_en = 1'b0;
        chk("t1_pixels", 32'(b), 32'hA5);
        chk("t1_underrun", 32'(underrun), 32'd0);

        // Full line with continuous pixel enable
        base = nreq;
        start_line(9'd3);
        step(); step(); step(); step(); step();
        pix_en = 1'b1;
        for (int c = 0; c < 80; c++) begin
            grab_byte(b);
            code = 8'(32'h41 + c);
            w = mem_rd({1'b0, code, 4'd3});
            chk($sformatf("line_cell%0d", c), 32'(b), 32'(w[7:0]));
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk("line_tail_pixel", 32'(pixel), 32'd0);
        end
        pix_en = 1'b0;
        chk("line_nreq", 32'(nreq - base), 32'd160);
        chk("line_idle_cs", 32'(cs), 32'd0);
        chk("line_underrun", 32'(underrun), 32'd0);

        // Pixel demanded 2 cycles after line start: underrun, sticky
        start_line(9'd3);
        step();
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        chk("ur_pixel", 32'(pixel), 32'd0);
        chk("ur_set", 32'(underrun), 32'd1);
        step(); step(); step();
        start_line(9'd3);
        step(); step();
        chk("ur_sticky", 32'(underrun), 32'd1);
        rst = 1'b1;
        #1;
        chk("ur_reset", 32'(underrun), 32'd0);
        chk("ur_reset_cs", 32'(cs), 32'd0);
        #3;
        rst = 1'b0;
        step();

        // Line start during SCR_REQ aborts: new row 2 address, stale ack dropped
        base = nreq;
        line_start = 1'b1;
        y = 9'd3;
        step();
        chk("ab_old_addr", 32'(addr), 32'h1000);
        y = 9'd35;
        step();
        line_start = 1'b0;
        chk("ab_new_cs", 32'(cs), 32'd1);
        chk("ab_new_addr", 32'(addr), 32'h10A0);
        step();
        step();
        chk("ab_fnt_addr", 32'(addr), 32'h0513);
        step(); step();
        chk("ab_nreq", 32'(nreq - base), 32'd3);
        step();
        pix_en = 1'b1;
        grab_byte(b);
        pix_en = 1'b0;
        chk("ab_pixels", 32'(b), 32'h62);
        chk("ab_underrun", 32'(underrun), 32'd0);

        // Line 15 of cell (0,0): cursor forces solid row, otherwise font data
`ifdef TEXT_CURSOR_EN
        cursor_on = 1'b1;
        cursor_col = 7'd0;
        cursor_row = 5'd0;
`endif
        start_line(9'd15);
        step(); step(); step(); step(); step();
        pix_en = 1'b1;
        grab_byte(b);
        pix_en = 1'b0;
`ifdef TEXT_CURSOR_EN
        chk("y15_pixels", 32'(b), 32'hFF);
`else
        chk("y15_pixels", 32'(b), 32'hBE);
`endif
        chk("y15_underrun", 32'(underrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_fetch.md
# text_fetch

Bus initiator for the monochrome VGA text path: at each active scanline it walks the character row, reading a screen word and then a font word per cell from the shared 16-bit memory responder. It serialises the 8-bit glyph row into a 1-bit pixel stream. It sits between the memory (`i_cs`/`i_we`/`o_ack` responder, 13-bit word address) and the VGA output stage, which supplies line start and pixel-enable strobes.

## Interface
Parameters:
- `COLS`, 80: character cells per line.
- `SCREEN_BASE`, 13'h1000: word address of screen cell (0,0).
- `FONT_BASE`, 13'h0000: word address of glyph 0, line 0.

Ports (clock and reset first):
- `i_clk`  in  1  single system clock; also the pixel clock domain.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_line_start`  in  1  one-cycle pulse in hblank, before each active line.
- `i_y`  in  9  pixel row of the upcoming line; sampled on `i_line_start`.
- `i_pix_en`  in  1  advance one pixel this cycle.
- `o_pixel`  out  1  registered pixel, valid the cycle after `i_pix_en`.
- `o_underrun`  out  1  sticky; set when a glyph is needed but not yet fetched.
- `o_addr`  out  13  memory word address.
- `o_cs`  out  1  memory request strobe.
- `o_we`  out  1  tied 0 (read-only initiator).
- `i_dat`  in  16  memory read data, valid while `i_ack` is high.
- `i_ack`  in  1  memory acknowledge; arrives exactly one cycle after `o_cs`.

## Operation
- Screen word: bits [7:0] hold the character code; bits [15:8] are ignored. Font word: bits [7:0] hold the glyph row, MSB leftmost.
- On `i_line_start`:
  - latch `row = i_y[8:4]` and `gl = i_y[3:0]`;
  - set `col = 0`;
  - clear the prefetch buffer and the shifter;
  - go to SCR_REQ. This applies from any state and takes priority.
- FSM:
  - IDLE: no requests.
  - SCR_REQ: `o_cs = 1`, `o_addr = SCREEN_BASE + row*COLS + col` (mod 2^13). Next state is SCR_WAIT.
  - SCR_WAIT: on `i_ack`, latch `chr = i_dat[7:0]` and go to FNT_REQ.
  - FNT_REQ: `o_cs = 1`, `o_addr = FONT_BASE + {chr, gl}`. Next state is FNT_WAIT.
  - FNT_WAIT: on `i_ack`, write `i_dat[7:0]` to the buffer, set buffer-full, `col++`, and go to FULL.
  - FULL: when the shifter takes the buffer, go to IDLE if `col == COLS`, otherwise go to SCR_REQ.
- `i_ack` is captured only in the WAIT states. Acks arriving in any other state are discarded, which covers stale acks after an abort.
- Shifter with a 3-bit count. On an `i_pix_en` cycle:
  - if count is 0 and the buffer is full: load the buffer, emit bit 7, and clear buffer-full;
  - if count is nonzero: emit the next bit;
  - if count is 0 and the buffer is empty: emit 0, and set `o_underrun` unless all COLS cells of the line have already been emitted.
- A load and a buffer write in the same cycle never collide: the buffer is written only in FNT_WAIT and is never full there.
- After COLS cells, `i_pix_en` yields 0 with no underrun.

## Timing
- Reset values: `o_cs` 0, `o_addr` 0, `o_we` 0, `o_pixel` 0, `o_underrun` 0, FSM in IDLE, `col` 0, buffer empty, shifter count 0.
- Fetch cost: 4 cycles per cell (REQ, WAIT, REQ, WAIT). The buffer is full 4 cycles after `i_line_start`.
- The caller issues `i_line_start` at least 6 cycles before the first `i_pix_en` of the line.
- With `i_pix_en` high every cycle (8 cycles per cell), no underrun occurs.
- `o_pixel` latency is 1 cycle from `i_pix_en`. It holds its value when `i_pix_en` is low.
- `o_cs` is high for exactly one cycle per request. At most one request is outstanding.
- `o_underrun` clears only on `i_reset`.

## Configuration
- `TEXT_CURSOR_EN` defined:
  - adds inputs `i_cursor_on` (1), `i_cursor_col` (7), `i_cursor_row` (5);
  - when `i_cursor_on`, the cell matches col and row, and `gl` is 14 or 15, the glyph byte written to the buffer is forced to 8'hFF.
- Not defined: these ports are absent and glyph bytes pass unmodified.

## Structure
- Shared package `vga_text_pkg` holds:
  - `FONT_H` = 16, the default `COLS`/`ROWS`, `SCREEN_BASE`, `FONT_BASE`;
  - the FSM state encoding (IDLE, SCR_REQ, SCR_WAIT, FNT_REQ, FNT_WAIT, FULL).
- One sub-module, `glyph_shifter`: the 8-bit buffer, shift register and count, producing the pixel/underrun outputs.

## Test plan
- Screen[0x1000] = 0x0041, font[0x41*16 + 3] = 0x00A5, `i_line_start` with `i_y` = 3, then 8 `i_pix_en` -> `o_addr` 0x1000 then 0x0413; `o_pixel` = 1,0,1,0,0,1,0,1; `o_underrun` = 0.
- `i_y` = 35 (row 2) -> first screen address 0x1000 + 160 = 0x10A0; font address uses `gl` = 3.
- Continuous `i_pix_en` for 640 cycles -> 160 requests, `col` reaches 80, FSM in IDLE, no underrun; extra `i_pix_en` cycles output 0.
- `i_pix_en` 2 cycles after `i_line_start` -> `o_pixel` = 0 and `o_underrun` = 1, held until `i_reset`.
- `i_line_start` asserted in the SCR_REQ cycle -> the stale ack is ignored, a new SCR_REQ follows with `col` = 0, and glyph data comes from the new row.
- With `TEXT_CURSOR_EN`: cursor at (0,0), `i_y` = 15 -> 8 pixels all 1 regardless of font data.
